silife_grid_scheduler: RTL and testbench
========================================

Name: silife_grid_scheduler

Overview:
- Sits between the grid, the SPI grid loader and the host (Wishbone-side) writer.
- Shares the grid's single row-write port (row select plus set/clear masks) between loader and host.
- Sequences generation-step pulses, either free-running at a programmed period or single-stepped.
- Guarantees a generation step never coincides with, or interleaves into, an active load session.

Parameters:
- WIDTH, 32, cells per row; width of the set/clear masks.
- HEIGHT, 32, rows in the grid; ROW_BITS = $clog2(HEIGHT).
- PERIOD_BITS, 24, width of the run-period register.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- i_ldr_active  input  1  loader session open (load CS low, already synchronised)
- i_ldr_selected  input  1  loader write strobe, one cycle, no backpressure
- i_ldr_row  input  ROW_BITS  loader row
- i_ldr_set / i_ldr_clear  input  WIDTH each  loader masks
- i_host_req  input  1  host write request, held until ack
- i_host_row  input  ROW_BITS  host row
- i_host_set / i_host_clear  input  WIDTH each  host masks
- o_host_ack  output  1  one-cycle ack, write accepted
- i_enable  input  1  free-run mode
- i_step  input  1  single-step pulse, honoured only when i_enable=0
- i_period  input  PERIOD_BITS  cycles between run steps, minus one
- o_row_select  output  ROW_BITS  grid row select
- o_set_cells / o_clear_cells  output  WIDTH each  grid masks
- o_gen_pulse  output  1  one-cycle generation-advance strobe to the grid
- o_pending  output  1  a generation is owed but not yet issued
- o_generation  output  16  count of issued generation pulses

Behaviour:
- Reset (reset_n=0 at a clk edge), applied mid-operation too: all outputs 0, counter 0, pending cleared, FSM in IDLE.
- Clock and reset: one clock; reset is synchronous and active-low.
- Write arbitration, per cycle:
  - The loader always wins; its write cannot be stalled.
  - The host is granted only when i_ldr_selected=0 and no o_gen_pulse is being issued in that cycle.
  - Grant cycle: o_host_ack=1 for exactly one cycle. The host must drop i_host_req or present a new request the following cycle.
- Write path latency: exactly 1 cycle, registered. The winning row and masks appear on the outputs the cycle after the strobe or grant.
- Idle write output: set/clear masks are 0 in any cycle without a write. o_row_select holds its last value.
- Set and clear both high on the same bit: forwarded unchanged; the grid gives set priority.
- FSM states:
  - IDLE: i_enable rising loads the down-counter with i_period and moves to RUN. i_step=1 sets pending.
  - RUN: counter decrements each cycle. At 0 it sets pending and reloads i_period. i_enable=0 returns to IDLE; an already-set pending survives.
  - ISSUE: entered when pending=1, i_ldr_active=0, i_ldr_selected=0 and no host grant this cycle. o_gen_pulse=1 (registered, 1 cycle), pending cleared, o_generation increments (16-bit wrap, 0xFFFF to 0). Returns to RUN if i_enable=1, else IDLE.
- Issue condition is checked from both IDLE and RUN. A pending generation has priority over a host request in the same cycle; the host waits.
- Unobstructed run: pulses spaced exactly i_period+1 cycles apart. i_period=0 gives a pulse every other cycle (ISSUE takes one cycle).
- Deferral:
  - While i_ldr_active=1, pending holds.
  - Period expiries that occur while already pending coalesce into one; there is no catch-up burst.
  - Pulse is issued 1 cycle after i_ldr_active falls.
- i_step while i_enable=1: ignored.
- i_period changes: take effect at the next reload only.

Decomposition:
- Shared package: FSM state encoding (IDLE, RUN, ISSUE), ROW_BITS derivation, generation-counter width constant.
- One natural sub-module: silife_period_timer (down-counter, reload, expire pulse).
- Arbitration and FSM stay in the top.

Test Plan:
- Reset while running with pending=1 → next cycle all outputs 0, o_generation=0, no o_gen_pulse.
- i_enable=1, i_period=4, no writes → o_gen_pulse on cycles 5, 10, 15 after enable; o_generation=3.
- Host req row 7, set=0x0000_0001, concurrent with loader strobe row 3 set=0x8000_0000 → row 3 output next cycle; host ack one cycle later; row 7 with 0x1 on the following cycle.
- i_ldr_active=1 for 50 cycles with i_period=9 → no pulses, o_pending=1. Pulse exactly 1 cycle after i_ldr_active falls; o_generation increments by exactly 1.
- i_enable=0, i_step pulse while host holds req → gen pulse first, host ack the next cycle; then i_step with i_enable=1 gives no pulse.
- Force o_generation to 0xFFFF, issue one step → o_generation=0x0000.

Source files
------------

// File: rtl/silife_grid_scheduler_pkg.sv
// Shared types and constants for the grid scheduler: FSM encoding, row-width
// derivation and generation-counter width.
package silife_grid_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ISSUE = 2'd2
    } sched_state_e;

    localparam int unsigned GEN_BITS = 16;

    // Row-select width; a one-row grid still needs a 1-bit select.
    function automatic int unsigned row_bits(input int unsigned height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

endpackage

// File: rtl/silife_period_timer.sv
// Run-period down-counter: loads on request, counts while running and flags
// expiry (count at zero) in the same cycle it reloads.
module silife_period_timer #(
    parameter int unsigned PERIOD_BITS = 24
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_load,
    input  logic                   i_run,
    input  logic [PERIOD_BITS-1:0] i_period,
    output logic                   o_expire_c
);

    logic [PERIOD_BITS-1:0] r_count;

    assign o_expire_c = i_run && (r_count == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_period;
        end else if (i_run) begin
            // A new period value is only picked up here, at reload.
            if (r_count == '0) r_count <= i_period;
            else               r_count <= r_count - PERIOD_BITS'(1);
        end
    end

endmodule

// File: rtl/silife_grid_scheduler.sv
// Shares the grid row-write port between SPI loader and host, and sequences
// generation pulses so they never land inside a load session.
module silife_grid_scheduler
    import silife_grid_scheduler_pkg::*;
#(
    parameter  int unsigned WIDTH       = 32,
    parameter  int unsigned HEIGHT      = 32,
    parameter  int unsigned PERIOD_BITS = 24,
    localparam int unsigned ROW_BITS    = row_bits(HEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_ldr_active,
    input  logic                   i_ldr_selected,
    input  logic [ROW_BITS-1:0]    i_ldr_row,
    input  logic [WIDTH-1:0]       i_ldr_set,
    input  logic [WIDTH-1:0]       i_ldr_clear,
    input  logic                   i_host_req,
    input  logic [ROW_BITS-1:0]    i_host_row,
    input  logic [WIDTH-1:0]       i_host_set,
    input  logic [WIDTH-1:0]       i_host_clear,
    output logic                   o_host_ack,
    input  logic                   i_enable,
    input  logic                   i_step,
    input  logic [PERIOD_BITS-1:0] i_period,
    output logic [ROW_BITS-1:0]    o_row_select,
    output logic [WIDTH-1:0]       o_set_cells,
    output logic [WIDTH-1:0]       o_clear_cells,
    output logic                   o_gen_pulse,
    output logic                   o_pending,
    output logic [15:0]            o_generation
);

    sched_state_e          r_state;
    sched_state_e          w_state_next;
    logic                  r_pending;
    logic                  w_pending_next;
    logic                  r_enable_q;
    logic                  r_gen_pulse;
    logic [GEN_BITS-1:0]   r_generation;
    logic [ROW_BITS-1:0]   r_row;
    logic [WIDTH-1:0]      r_set;
    logic [WIDTH-1:0]      r_clr;
    logic                  r_host_ack;

    logic w_timer_load;
    logic w_timer_run;
    logic w_expire;
    logic w_pend_eff;
    logic w_issue;
    logic w_grant;

    // Timer follows i_enable: loads on its rising edge, runs while it stays high.
    assign w_timer_load = i_enable && !r_enable_q;
    assign w_timer_run  = i_enable && r_enable_q;

    silife_period_timer #(
        .PERIOD_BITS (PERIOD_BITS)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_timer_load),
        .i_run      (w_timer_run),
        .i_period   (i_period),
        .o_expire_c (w_expire)
    );

    // A pending generation beats a host request; the loader beats both.
    assign w_pend_eff = r_pending || w_expire || (i_step && !i_enable);
    assign w_issue    = (r_state != ST_ISSUE) && w_pend_eff
                        && !i_ldr_active && !i_ldr_selected;
    assign w_grant    = i_host_req && !i_ldr_selected && !w_issue && !r_host_ack;

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = w_issue ? 1'b0 : w_pend_eff;
        unique case (r_state)
            ST_IDLE: begin
                if (w_issue)       w_state_next = ST_ISSUE;
                else if (i_enable) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_issue)        w_state_next = ST_ISSUE;
                else if (!i_enable) w_state_next = ST_IDLE;
            end
            ST_ISSUE: begin
                w_state_next = i_enable ? ST_RUN : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_pending    <= 1'b0;
            r_enable_q   <= 1'b0;
            r_gen_pulse  <= 1'b0;
            r_generation <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pending   <= w_pending_next;
            r_enable_q  <= i_enable;
            r_gen_pulse <= w_issue;
            if (w_issue) r_generation <= r_generation + GEN_BITS'(1);
        end
    end

    // Row-write port: row select holds between writes, masks idle at zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_row      <= '0;
            r_set      <= '0;
            r_clr      <= '0;
            r_host_ack <= 1'b0;
        end else begin
            r_host_ack <= w_grant;
            if (i_ldr_selected) begin
                r_row <= i_ldr_row;
                r_set <= i_ldr_set;
                r_clr <= i_ldr_clear;
            end else if (w_grant) begin
                r_row <= i_host_row;
                r_set <= i_host_set;
                r_clr <= i_host_clear;
            end else begin
                r_set <= '0;
                r_clr <= '0;
            end
        end
    end

    assign o_host_ack    = r_host_ack;
    assign o_row_select  = r_row;
    assign o_set_cells   = r_set;
    assign o_clear_cells = r_clr;
    assign o_gen_pulse   = r_gen_pulse;
    assign o_pending     = r_pending;
    assign o_generation  = r_generation;

endmodule

// File: tb/tb_silife_grid_scheduler.sv
// Directed and randomized checks of the grid scheduler against a deadline-based
// reference model of write arbitration and generation sequencing.
module tb_silife_grid_scheduler;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned ROW_BITS    = 5;
    localparam int unsigned PERIOD_BITS = 24;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   ldr_active = 1'b0;
    logic                   ldr_sel = 1'b0;
    logic [ROW_BITS-1:0]    ldr_row = '0;
    logic [WIDTH-1:0]       ldr_set = '0;
    logic [WIDTH-1:0]       ldr_clr = '0;
    logic                   host_req = 1'b0;
    logic [ROW_BITS-1:0]    host_row = '0;
    logic [WIDTH-1:0]       host_set = '0;
    logic [WIDTH-1:0]       host_clr = '0;
    logic                   host_ack;
    logic                   enable = 1'b0;
    logic                   step = 1'b0;
    logic [PERIOD_BITS-1:0] period = '0;
    logic [ROW_BITS-1:0]    row_select;
    logic [WIDTH-1:0]       set_cells;
    logic [WIDTH-1:0]       clear_cells;
    logic                   gen_pulse;
    logic                   pending;
    logic [15:0]            generation;

    int n_cmp = 0;
    int n_err = 0;

    silife_grid_scheduler #(
        .WIDTH       (WIDTH),
        .HEIGHT      (32),
        .PERIOD_BITS (PERIOD_BITS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_ldr_active   (ldr_active),
        .i_ldr_selected (ldr_sel),
        .i_ldr_row      (ldr_row),
        .i_ldr_set      (ldr_set),
        .i_ldr_clear    (ldr_clr),
        .i_host_req     (host_req),
        .i_host_row     (host_row),
        .i_host_set     (host_set),
        .i_host_clear   (host_clr),
        .o_host_ack     (host_ack),
        .i_enable       (enable),
        .i_step         (step),
        .i_period       (period),
        .o_row_select   (row_select),
        .o_set_cells    (set_cells),
        .o_clear_cells  (clear_cells),
        .o_gen_pulse    (gen_pulse),
        .o_pending      (pending),
        .o_generation   (generation)
    );

    always #5 clk = ~clk;

    // Reference model: absolute-cycle deadlines for period expiry, an owed flag,
    // and the expected registered outputs after the coming edge.
    longint          cyc = 0;
    longint          m_deadline = 0;
    bit              m_en_prev = 0;
    bit              m_pend = 0;
    bit              m_pulsed = 0;
    bit              m_acked = 0;
    logic [15:0]     m_gen = '0;
    logic [ROW_BITS-1:0] e_row = '0;
    logic [WIDTH-1:0]    e_set = '0;
    logic [WIDTH-1:0]    e_clr = '0;

    task automatic model_eval();
        bit expire, owed, issue, grant;
        if (!reset_n) begin
            m_en_prev = 0; m_pend = 0; m_pulsed = 0; m_acked = 0; m_gen = '0;
            e_row = '0; e_set = '0; e_clr = '0;
        end else begin
            expire = 0;
            if (enable && m_en_prev && cyc == m_deadline) begin
                expire = 1;
                m_deadline = cyc + longint'(period) + 1;
            end
            if (enable && !m_en_prev) m_deadline = cyc + longint'(period) + 1;
            m_en_prev = enable;
            owed  = m_pend || expire || (step && !enable);
            issue = !m_pulsed && owed && !ldr_active && !ldr_sel;
            grant = host_req && !ldr_sel && !issue && !m_acked;
            m_pend   = owed && !issue;
            m_pulsed = issue;
            if (issue) m_gen = m_gen + 16'd1;
            m_acked = grant;
            if (ldr_sel) begin
                e_row = ldr_row; e_set = ldr_set; e_clr = ldr_clr;
            end else if (grant) begin
                e_row = host_row; e_set = host_set; e_clr = host_clr;
            end else begin
                e_set = '0; e_clr = '0;
            end
        end
        cyc++;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        cmp("row_select", 32'(row_select), 32'(e_row));
        cmp("set_cells", set_cells, e_set);
        cmp("clear_cells", clear_cells, e_clr);
        cmp("host_ack", 32'(host_ack), 32'(m_acked));
        cmp("gen_pulse", 32'(gen_pulse), 32'(m_pulsed));
        cmp("pending", 32'(pending), 32'(m_pend));
        cmp("generation", 32'(generation), 32'(m_gen));
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int pulses;
        logic [15:0] g0;

        // Reset
        reset_n = 1'b0;
        tick(); tick();
        cmp("reset_gen", 32'(generation), 32'd0);
        cmp("reset_set", set_cells, 32'd0);
        reset_n = 1'b1;
        tick();

        // Free run, period 4: pulses 5, 10, 15 cycles after enable
        enable = 1'b1; period = 24'd4;
        for (int i = 1; i <= 16; i++) begin
            tick();
            cmp("run_pulse_slot", 32'(gen_pulse), 32'((i == 6) || (i == 11) || (i == 16)));
        end
        cmp("run_gen3", 32'(generation), 32'd3);
        enable = 1'b0;
        tick(); tick();

        // Loader and host collide: loader first, host right after
        ldr_sel = 1'b1; ldr_row = 5'd3; ldr_set = 32'h8000_0000; ldr_clr = '0;
        host_req = 1'b1; host_row = 5'd7; host_set = 32'h0000_0001; host_clr = '0;
        tick();
        cmp("collide_ldr_row", 32'(row_select), 32'd3);
        cmp("collide_ldr_set", set_cells, 32'h8000_0000);
        cmp("collide_no_ack", 32'(host_ack), 32'd0);
        ldr_sel = 1'b0;
        tick();
        cmp("collide_host_ack", 32'(host_ack), 32'd1);
        cmp("collide_host_row", 32'(row_select), 32'd7);
        cmp("collide_host_set", set_cells, 32'h0000_0001);
        host_req = 1'b0;
        tick();
        cmp("idle_set_zero", set_cells, 32'd0);
        cmp("idle_row_hold", 32'(row_select), 32'd7);

        // Load session defers a running generation
        ldr_active = 1'b1; enable = 1'b1; period = 24'd9;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (gen_pulse) pulses++;
        end
        cmp("defer_no_pulse", 32'(pulses), 32'd0);
        cmp("defer_pending", 32'(pending), 32'd1);
        g0 = generation;
        ldr_active = 1'b0;
        tick();
        cmp("defer_release_pulse", 32'(gen_pulse), 32'd1);
        cmp("defer_gen_plus1", 32'(generation), 32'(g0 + 16'd1));
        enable = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Single step beats a waiting host; host follows next cycle
        host_req = 1'b1; host_row = 5'd5; host_set = 32'h00F0_0000; host_clr = 32'h0000_000F;
        step = 1'b1;
        tick();
        cmp("step_pulse", 32'(gen_pulse), 32'd1);
        cmp("step_host_wait", 32'(host_ack), 32'd0);
        step = 1'b0;
        tick();
        cmp("step_host_ack", 32'(host_ack), 32'd1);
        cmp("step_host_clr", clear_cells, 32'h0000_000F);
        host_req = 1'b0;
        enable = 1'b1; step = 1'b1; period = 24'd9;
        tick();
        step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("step_ignored", 32'(gen_pulse), 32'd0);
        end
        enable = 1'b0;
        tick(); tick();

        // Generation counter wrap
        force dut.r_generation = 16'hFFFF;
        #1;
        release dut.r_generation;
        m_gen = 16'hFFFF;
        step = 1'b1;
        tick();
        step = 1'b0;
        cmp("gen_wrap", 32'(generation), 32'd0);
        tick();

        // Reset mid-run with a generation owed
        enable = 1'b1; period = 24'd0; ldr_active = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        cmp("pre_reset_pending", 32'(pending), 32'd1);
        reset_n = 1'b0;
        tick();
        cmp("mid_reset_pending", 32'(pending), 32'd0);
        cmp("mid_reset_gen", 32'(generation), 32'd0);
        cmp("mid_reset_pulse", 32'(gen_pulse), 32'd0);
        reset_n = 1'b1; ldr_active = 1'b0; enable = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 19) == 0) ldr_active = ~ldr_active;
            ldr_sel = ($urandom_range(0, 3) == 0);
            ldr_row = 5'($urandom);
            ldr_set = $urandom;
            ldr_clr = $urandom;
            if (host_req && host_ack) begin
                host_req = $urandom_range(0, 1) == 1;
                host_row = 5'($urandom); host_set = $urandom; host_clr = $urandom;
            end else if (!host_req && $urandom_range(0, 2) == 0) begin
                host_req = 1'b1;
                host_row = 5'($urandom); host_set = $urandom; host_clr = $urandom;
            end
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            step = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 29) == 0) period = 24'($urandom_range(0, 7));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
